mem_access_ctrl: RTL and testbench

- Load/store access controller sitting directly upstream of the ROM/RAM memory system.
- Accepts one request at a time from the core over a valid/ready handshake and checks it for alignment and region legality.
- Drives the memory system's write_enable/address/write_data inputs and waits out the synchronous-RAM read latency.
- Returns load data or an error flag as a single-cycle response pulse.

---
 rtl/mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller in front of the
// ROM/RAM memory system. Checks alignment and region legality, drives the
// memory write_enable/address/write_data inputs, waits out the synchronous
// read latency and returns a one-cycle response pulse.
// Optional macro MEM_SUBWORD_STORE_EN enables byte/halfword stores to RAM
// through a read-modify-write sequence; without it such stores are rejected.
module mem_access_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE   = DATA_WIDTH'(32'h1000_0000),
  parameter int                    RAM_DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_write_enable_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

  // First byte address past the end of RAM
  localparam logic [DATA_WIDTH-1:0] RAM_LIMIT = RAM_BASE + DATA_WIDTH'(4 * RAM_DEPTH);

`ifdef MEM_SUBWORD_STORE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_STORE, S_LD_ADDR, S_LD_CAP, S_RESP, S_RMW_ADDR, S_RMW_CAP, S_RMW_WR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_STORE, S_LD_ADDR, S_LD_CAP, S_RESP
  } state_t;
`endif

  state_t                r_state, w_stateNext;
  logic [1:0]            r_size, w_sizeNext;
  logic [1:0]            r_lane, w_laneNext;
  logic                  r_rspValid, w_rspValidNext;
  logic                  r_rspErr, w_rspErrNext;
  logic [DATA_WIDTH-1:0] r_rspRdata, w_rspRdataNext;
  logic                  r_memWe, w_memWeNext;
  logic [DATA_WIDTH-1:0] r_memAddr, w_memAddrNext;
  logic [DATA_WIDTH-1:0] r_memWdata, w_memWdataNext;

  logic                  w_reqErr;
  logic [DATA_WIDTH-1:0] w_alignedAddr;
  logic [4:0]            w_shamt;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_loadData;

`ifdef MEM_SUBWORD_STORE_EN
  logic [DATA_WIDTH-1:0] r_wdata, w_wdataNext;
  logic [DATA_WIDTH-1:0] w_laneMask;
  logic [DATA_WIDTH-1:0] w_mergeMask;
  logic [DATA_WIDTH-1:0] w_merged;
`endif

  assign req_ready_o        = (r_state == S_IDLE);
  assign rsp_valid_o        = r_rspValid;
  assign rsp_err_o          = r_rspErr;
  assign rsp_rdata_o        = r_rspRdata;
  assign mem_write_enable_o = r_memWe;
  assign mem_address_o      = r_memAddr;
  assign mem_write_data_o   = r_memWdata;

  assign w_alignedAddr = {req_addr_i[DATA_WIDTH-1:2], 2'b00};
  assign w_shamt       = {r_lane, 3'b000};
  assign w_shifted     = mem_read_data_i >> w_shamt;

  // Legality of the incoming request, highest-priority rule first
  always_comb begin
    w_reqErr = 1'b0;
    if (req_size_i == 2'b11)
      w_reqErr = 1'b1;
    else if ((req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) ||
             (req_size_i == 2'b01 && req_addr_i[0]))
      w_reqErr = 1'b1;
    else if (req_we_i && req_addr_i < RAM_BASE)
      w_reqErr = 1'b1;
    else if (req_addr_i >= RAM_LIMIT)
      w_reqErr = 1'b1;
`ifndef MEM_SUBWORD_STORE_EN
    else if (req_we_i && req_size_i != 2'b10)
      w_reqErr = 1'b1;
`endif
  end

  // Little-endian lane extraction of the returned word, zero-extended
  always_comb begin
    w_loadData = mem_read_data_i;
    case (r_size)
      2'b00:   w_loadData = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      2'b01:   w_loadData = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: w_loadData = mem_read_data_i;
    endcase
  end

`ifdef MEM_SUBWORD_STORE_EN
  // Merge the right-aligned store lane(s) into the word read back from RAM
  always_comb begin
    w_laneMask  = (r_size == 2'b00) ? {{(DATA_WIDTH-8){1'b0}}, 8'hFF}
                                    : {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
    w_mergeMask = w_laneMask << w_shamt;
    w_merged    = (mem_read_data_i & ~w_mergeMask) | ((r_wdata << w_shamt) & w_mergeMask);
  end
`endif

  // Next-state and next-output decode; registered outputs hold unless changed
  always_comb begin
    w_stateNext    = r_state;
    w_sizeNext     = r_size;
    w_laneNext     = r_lane;
    w_rspValidNext = 1'b0;
    w_rspErrNext   = r_rspErr;
    w_rspRdataNext = r_rspRdata;
    w_memWeNext    = 1'b0;
    w_memAddrNext  = r_memAddr;
    w_memWdataNext = r_memWdata;
`ifdef MEM_SUBWORD_STORE_EN
    w_wdataNext    = r_wdata;
`endif
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_sizeNext = req_size_i;
          w_laneNext = req_addr_i[1:0];
          if (w_reqErr) begin
            w_stateNext    = S_RESP;
            w_rspValidNext = 1'b1;
            w_rspErrNext   = 1'b1;
            w_rspRdataNext = '0;
          end else if (req_we_i && req_size_i == 2'b10) begin
            w_stateNext    = S_STORE;
            w_memWeNext    = 1'b1;
            w_memAddrNext  = req_addr_i;
            w_memWdataNext = req_wdata_i;
          end
`ifdef MEM_SUBWORD_STORE_EN
          else if (req_we_i) begin
            w_stateNext   = S_RMW_ADDR;
            w_memAddrNext = w_alignedAddr;
            w_wdataNext   = req_wdata_i;
          end
`endif
          else begin
            w_stateNext   = S_LD_ADDR;
            w_memAddrNext = w_alignedAddr;
          end
        end
      end
      S_STORE: begin
        w_stateNext    = S_RESP;
        w_rspValidNext = 1'b1;
        w_rspErrNext   = 1'b0;
        w_rspRdataNext = '0;
      end
      S_LD_ADDR: begin
        w_stateNext = S_LD_CAP;
      end
      S_LD_CAP: begin
        w_stateNext    = S_RESP;
        w_rspValidNext = 1'b1;
        w_rspErrNext   = 1'b0;
        w_rspRdataNext = w_loadData;
      end
`ifdef MEM_SUBWORD_STORE_EN
      S_RMW_ADDR: begin
        w_stateNext = S_RMW_CAP;
      end
      S_RMW_CAP: begin
        w_stateNext    = S_RMW_WR;
        w_memWeNext    = 1'b1;
        w_memWdataNext = w_merged;
      end
      S_RMW_WR: begin
        w_stateNext    = S_RESP;
        w_rspValidNext = 1'b1;
        w_rspErrNext   = 1'b0;
        w_rspRdataNext = '0;
      end
`endif
      S_RESP: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_size     <= 2'b00;
      r_lane     <= 2'b00;
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspRdata <= '0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
`ifdef MEM_SUBWORD_STORE_EN
      r_wdata    <= '0;
`endif
    end else begin
      r_state    <= w_stateNext;
      r_size     <= w_sizeNext;
      r_lane     <= w_laneNext;
      r_rspValid <= w_rspValidNext;
      r_rspErr   <= w_rspErrNext;
      r_rspRdata <= w_rspRdataNext;
      r_memWe    <= w_memWeNext;
      r_memAddr  <= w_memAddrNext;
      r_memWdata <= w_memWdataNext;
`ifdef MEM_SUBWORD_STORE_EN
      r_wdata    <= w_wdataNext;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: drives directed then random requests into
// mem_access_ctrl, emulates the synchronous ROM/RAM behind it, and checks
// every output each cycle against a transaction-level model of the rules.
module tb_mem_access_ctrl;

  localparam int          DW        = 32;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam int          RAM_DEPTH = 32;
  localparam logic [31:0] RAM_LIMIT = RAM_BASE + 32'(4 * RAM_DEPTH);
  localparam int          NCYC      = 3000;
`ifdef MEM_SUBWORD_STORE_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          hasLit;
    logic        litErr;
    logic [31:0] litRdata;
    bit          rstCap;
  } req_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [1:0]    req_size_i = 2'b00;
  logic [DW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          mem_write_enable_o;
  logic [DW-1:0] mem_address_o;
  logic [DW-1:0] mem_write_data_o;
  logic [DW-1:0] mem_read_data_i = '0;

  mem_access_ctrl #(
    .DATA_WIDTH(DW),
    .RAM_BASE  (RAM_BASE),
    .RAM_DEPTH (RAM_DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_we_i          (req_we_i),
    .req_size_i        (req_size_i),
    .req_addr_i        (req_addr_i),
    .req_wdata_i       (req_wdata_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_rdata_o       (rsp_rdata_o),
    .rsp_err_o         (rsp_err_o),
    .mem_write_enable_o(mem_write_enable_o),
    .mem_address_o     (mem_address_o),
    .mem_write_data_o  (mem_write_data_o),
    .mem_read_data_i   (mem_read_data_i)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: one transaction outstanding at most
  int          busyUntil     = -1;
  int          expRspCycle   = -1;
  int          expWeCycle    = -1;
  int          pendAddrCycle = -1;
  int          resetAtCycle  = -1;
  bit          resetHold     = 1'b0;
  logic [31:0] pendAddr      = '0;
  logic [31:0] curAddr       = '0;
  logic [31:0] expRdata      = '0;
  logic [31:0] expWeData     = '0;
  bit          expErr        = 1'b0;
  bit          expChkData    = 1'b0;
  bit          expLit        = 1'b0;
  logic        expLitErr     = 1'b0;
  logic [31:0] expLitRdata   = '0;

  logic [31:0] refMem [RAM_DEPTH];
  logic [31:0] simMem [RAM_DEPTH];
  req_t        dirQ [$];

  always #5 clk = ~clk;

  // Cycle counter, observed on falling edges
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit inRam(input logic [31:0] a);
    return (a >= RAM_BASE) && (a < RAM_LIMIT);
  endfunction

  function automatic int ramIdx(input logic [31:0] a);
    return int'((a - RAM_BASE) >> 2);
  endfunction

  // Synchronous ROM/RAM: one-cycle read latency, write on the clock edge
  always @(posedge clk) begin
    if (mem_write_enable_o && inRam(mem_address_o))
      simMem[ramIdx(mem_address_o)] <= mem_write_data_o;
    mem_read_data_i <= inRam(mem_address_o) ? simMem[ramIdx(mem_address_o)]
                                            : romWord(mem_address_o);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkResetState();
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    check("rst_mem_we", 32'(mem_write_enable_o), 32'd0);
    check("rst_mem_addr", mem_address_o, 32'd0);
    check("rst_mem_wdata", mem_write_data_o, 32'd0);
  endtask

  // Compare every DUT output against the model for the current cycle
  task automatic checkOutput();
    bit expValid;
    bit expWe;
    if (cyc == pendAddrCycle) curAddr = pendAddr;
    expValid = (cyc == expRspCycle);
    expWe    = (cyc == expWeCycle);
    if (resetHold) checkResetState();
    check("req_ready", 32'(req_ready_o), 32'(cyc > busyUntil));
    check("rsp_valid", 32'(rsp_valid_o), 32'(expValid));
    check("mem_we", 32'(mem_write_enable_o), 32'(expWe));
    check("mem_addr", mem_address_o, curAddr);
    if (expValid) begin
      check("rsp_err", 32'(rsp_err_o), 32'(expErr));
      if (expChkData) check("rsp_rdata", rsp_rdata_o, expRdata);
      if (expLit) check("lit_err", 32'(rsp_err_o), 32'(expLitErr));
      if (expLit && expChkData) check("lit_rdata", rsp_rdata_o, expLitRdata);
    end
    if (expWe) check("mem_wdata", mem_write_data_o, expWeData);
  endtask

  // Transaction-level model of one accepted request in cycle cyc
  task automatic modelAccept(input req_t r);
    int          n;
    int          lat;
    int          sh;
    bit          err;
    logic [31:0] aligned;
    logic [31:0] word;
    logic [31:0] mask;
    n       = cyc;
    sh      = 8 * int'(r.addr[1:0]);
    aligned = r.addr & ~32'd3;
    err = (r.size == 2'b11) ||
          (r.size == 2'b10 && r.addr[1:0] != 2'b00) ||
          (r.size == 2'b01 && r.addr[0]) ||
          (r.we && r.addr < RAM_BASE) ||
          (r.addr >= RAM_LIMIT) ||
          (r.we && r.size != 2'b10 && !SUBWORD);
    expErr      = err;
    expLit      = r.hasLit;
    expLitErr   = r.litErr;
    expLitRdata = r.litRdata;
    if (err) begin
      lat        = 1;
      expRdata   = 32'd0;
      expChkData = 1'b1;
    end else if (r.we && r.size == 2'b10) begin
      lat        = 2;
      expWeCycle = n + 1;
      expWeData  = r.wdata;
      refMem[ramIdx(aligned)] = r.wdata;
      expChkData = 1'b0;
    end else if (r.we) begin
      lat        = 4;
      word       = refMem[ramIdx(aligned)];
      mask       = ((r.size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      word       = (word & ~mask) | ((r.wdata << sh) & mask);
      expWeCycle = n + 3;
      expWeData  = word;
      refMem[ramIdx(aligned)] = word;
      expChkData = 1'b0;
    end else begin
      lat        = 3;
      word       = inRam(aligned) ? refMem[ramIdx(aligned)] : romWord(aligned);
      word       = word >> sh;
      if (r.size == 2'b00) word = word & 32'hFF;
      else if (r.size == 2'b01) word = word & 32'hFFFF;
      expRdata   = word;
      expChkData = 1'b1;
    end
    if (!err) begin
      pendAddr      = (r.we && r.size == 2'b10) ? r.addr : aligned;
      pendAddrCycle = n + 1;
    end
    expRspCycle = n + lat;
    busyUntil   = n + lat;
    if (r.rstCap) resetAtCycle = n + 2;
  endtask

  function automatic req_t randReq();
    req_t r;
    int   sel;
    sel = $urandom_range(0, 9);
    if (sel < 6)      r.addr = RAM_BASE + 32'($urandom_range(0, 4 * RAM_DEPTH - 1));
    else if (sel < 8) r.addr = 32'($urandom_range(0, 255));
    else if (sel < 9) r.addr = RAM_LIMIT + 32'($urandom_range(0, 63));
    else              r.addr = $urandom;
    sel = $urandom_range(0, 7);
    r.size     = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel < 7) ? 2'b10 : 2'b11;
    r.we       = 1'($urandom_range(0, 1));
    r.wdata    = $urandom;
    r.hasLit   = 1'b0;
    r.litErr   = 1'b0;
    r.litRdata = '0;
    r.rstCap   = 1'b0;
    return r;
  endfunction

  // Drive the inputs for the coming clock edge and update the model on accept
  task automatic applyStimulus();
    req_t r;
    if (resetHold) begin
      reset       = 1'b0;
      resetHold   = 1'b0;
      req_valid_i = 1'b0;
      return;
    end
    if (cyc == resetAtCycle) begin
      reset         = 1'b1;
      req_valid_i   = 1'b0;
      resetHold     = 1'b1;
      resetAtCycle  = -1;
      expRspCycle   = -1;
      expWeCycle    = -1;
      pendAddrCycle = -1;
      busyUntil     = cyc;
      curAddr       = '0;
      return;
    end
    r = randReq();
    if (cyc <= busyUntil) begin
      req_valid_i = 1'($urandom_range(0, 1));
      req_we_i    = r.we;
      req_size_i  = r.size;
      req_addr_i  = r.addr;
      req_wdata_i = r.wdata;
      return;
    end
    if (dirQ.size() > 0) begin
      r = dirQ.pop_front();
    end else if ($urandom_range(0, 3) == 0) begin
      req_valid_i = 1'b0;
      req_addr_i  = r.addr;
      return;
    end
    req_valid_i = 1'b1;
    req_we_i    = r.we;
    req_size_i  = r.size;
    req_addr_i  = r.addr;
    req_wdata_i = r.wdata;
    modelAccept(r);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      v = $urandom;
      refMem[i] = v;
      simMem[i] = v;
    end

    dirQ.push_back('{1'b1, 2'b10, 32'h1000_0008, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0});
    dirQ.push_back('{1'b0, 2'b10, 32'h1000_0008, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
    dirQ.push_back('{1'b0, 2'b00, 32'h1000_000B, 32'h0, 1'b1, 1'b0, 32'h0000_00DE, 1'b0});
    dirQ.push_back('{1'b0, 2'b01, 32'h1000_000A, 32'h0, 1'b1, 1'b0, 32'h0000_DEAD, 1'b0});
    dirQ.push_back('{1'b1, 2'b10, 32'h0000_0010, 32'h1234_5678, 1'b1, 1'b1, 32'h0, 1'b0});
    dirQ.push_back('{1'b0, 2'b10, 32'h1000_0002, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0});
    dirQ.push_back('{1'b0, 2'b10, 32'h1000_0080, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0});
    dirQ.push_back('{1'b0, 2'b11, 32'h1000_0000, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0});
`ifdef MEM_SUBWORD_STORE_EN
    dirQ.push_back('{1'b1, 2'b00, 32'h1000_0009, 32'hFFFF_FF55, 1'b1, 1'b0, 32'h0, 1'b0});
    dirQ.push_back('{1'b0, 2'b10, 32'h1000_0008, 32'h0, 1'b1, 1'b0, 32'hDEAD_55EF, 1'b0});
    dirQ.push_back('{1'b0, 2'b10, 32'h1000_0008, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1});
    dirQ.push_back('{1'b0, 2'b10, 32'h1000_0008, 32'h0, 1'b1, 1'b0, 32'hDEAD_55EF, 1'b0});
`else
    dirQ.push_back('{1'b1, 2'b00, 32'h1000_0009, 32'hFFFF_FF55, 1'b1, 1'b1, 32'h0, 1'b0});
    dirQ.push_back('{1'b0, 2'b10, 32'h1000_0008, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
    dirQ.push_back('{1'b0, 2'b10, 32'h1000_0008, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1});
    dirQ.push_back('{1'b0, 2'b10, 32'h1000_0008, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkResetState();
    $display("[TB] reset released, running %0d cycles (subword stores %0d)", NCYC, SUBWORD);

    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      checkOutput();
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
